// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-state issue controller (IDLE -> ISSUE -> WB) that feeds
// an external combinational 8-bit ALU from a 9-bit instruction stream, owns the
// 8x8 register file and the architectural carry flag, and reports writebacks,
// taken branches and a sticky halt.
module alu_issue_ctrl #(
    parameter int REGS = 8,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    input  logic [8:0]   instr,
    output logic         instr_ready,
    output logic [2:0]   alu_cmd,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_sc_i,
    input  logic [W-1:0] alu_rslt,
    input  logic         alu_sc_o,
    input  logic         alu_absj,
    output logic         wb_valid,
    output logic [2:0]   wb_addr,
    output logic [W-1:0] wb_data,
    output logic         branch_taken,
    output logic [W-1:0] branch_target,
    output logic         carry,
    output logic         halted,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_LDI  = 3'b000,
        OP_HALT = 3'b001,
        OP_BNZ  = 3'b010,
        OP_XOR  = 3'b011,
        OP_ROT  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_ADD  = 3'b111
    } op_t;

    localparam logic [W-1:0] ROT_MASK = {{(W-3){1'b0}}, 3'b111};

    state_t         state_q,         state_d;
    op_t            op_q,            op_d;
    logic [2:0]     rd_q,            rd_d;
    logic [2:0]     imm_q,           imm_d;
    logic           instr_ready_q,   instr_ready_d;
    logic [2:0]     alu_cmd_q,       alu_cmd_d;
    logic [W-1:0]   alu_a_q,         alu_a_d;
    logic [W-1:0]   alu_b_q,         alu_b_d;
    logic           alu_sc_i_q,      alu_sc_i_d;
    logic           sc_q,            sc_d;
    logic           carry_wr_q,      carry_wr_d;
    logic           wb_valid_q,      wb_valid_d;
    logic [2:0]     wb_addr_q,       wb_addr_d;
    logic [W-1:0]   wb_data_q,       wb_data_d;
    logic           branch_taken_q,  branch_taken_d;
    logic [W-1:0]   branch_target_q, branch_target_d;
    logic           carry_q,         carry_d;
    logic           halted_q,        halted_d;
    logic [W-1:0]   rf_q [REGS];
    logic [W-1:0]   rf_d [REGS];

    op_t            in_op;
    logic [2:0]     in_rd;
    logic [2:0]     in_rs;
    logic           accept;

    // Instruction field decode and handshake qualification
    always_comb begin
        in_op  = op_t'(instr[8:6]);
        in_rd  = instr[5:3];
        in_rs  = instr[2:0];
        accept = instr_valid && instr_ready_q;
    end

    // Next-state, operand latch, result capture and register-file commit
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        rd_d            = rd_q;
        imm_d           = imm_q;
        alu_cmd_d       = alu_cmd_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_sc_i_d      = alu_sc_i_q;
        sc_d            = sc_q;
        carry_wr_d      = 1'b0;
        wb_valid_d      = 1'b0;
        wb_addr_d       = wb_addr_q;
        wb_data_d       = wb_data_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        carry_d         = carry_q;
        halted_d        = halted_q;
        rf_d            = rf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_op == OP_HALT) begin
                        halted_d = 1'b1;
                    end else begin
                        op_d    = in_op;
                        rd_d    = in_rd;
                        imm_d   = in_rs;
                        state_d = S_ISSUE;
                        if (in_op == OP_LDI) begin
                            alu_cmd_d = '0;
                        end else begin
                            alu_cmd_d  = in_op;
                            alu_a_d    = rf_q[in_rd];
                            alu_b_d    = (in_op == OP_ROT) ? (rf_q[in_rs] & ROT_MASK)
                                                           : rf_q[in_rs];
                            alu_sc_i_d = (in_op == OP_ADD) ? carry_q : 1'b0;
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d   = S_WB;
                wb_addr_d = rd_q;
                case (op_q)
                    OP_LDI: begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = {{(W-3){1'b0}}, imm_q};
                    end
                    OP_BNZ: begin
                        // alu_b still holds the unmasked R[rs] read at acceptance
                        branch_taken_d  = alu_absj;
                        branch_target_d = alu_b_q;
                    end
                    OP_ADD: begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_rslt;
                        sc_d       = alu_sc_o;
                        carry_wr_d = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_rslt;
                    end
                endcase
            end
            S_WB: begin
                state_d = S_IDLE;
                if (wb_valid_q) begin
                    rf_d[wb_addr_q] = wb_data_q;
                end
                if (carry_wr_q) begin
                    carry_d = sc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        instr_ready_d = (state_d == S_IDLE) && !halted_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            op_q            <= OP_LDI;
            rd_q            <= '0;
            imm_q           <= '0;
            instr_ready_q   <= 1'b0;
            alu_cmd_q       <= '0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_sc_i_q      <= 1'b0;
            sc_q            <= 1'b0;
            carry_wr_q      <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_addr_q       <= '0;
            wb_data_q       <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            carry_q         <= 1'b0;
            halted_q        <= 1'b0;
            for (int unsigned i = 0; i < REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            rd_q            <= rd_d;
            imm_q           <= imm_d;
            instr_ready_q   <= instr_ready_d;
            alu_cmd_q       <= alu_cmd_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_sc_i_q      <= alu_sc_i_d;
            sc_q            <= sc_d;
            carry_wr_q      <= carry_wr_d;
            wb_valid_q      <= wb_valid_d;
            wb_addr_q       <= wb_addr_d;
            wb_data_q       <= wb_data_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            carry_q         <= carry_d;
            halted_q        <= halted_d;
            for (int unsigned i = 0; i < REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_ready   = instr_ready_q;
    assign alu_cmd       = alu_cmd_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sc_i      = alu_sc_i_q;
    assign wb_valid      = wb_valid_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign carry         = carry_q;
    assign halted        = halted_q;
    assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [8:0] instr = '0;
    logic       instr_ready;
    logic [2:0] alu_cmd;
    logic [7:0] alu_a, alu_b;
    logic       alu_sc_i;
    logic [7:0] alu_rslt;
    logic       alu_sc_o;
    logic       alu_absj;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       carry;
    logic       halted;
    logic [2:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_prev = 0;
    int acc_now = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: ADD with carry-in, rotate-left, logic ops, nonzero test
    logic [8:0]  sum;
    logic [15:0] rot;
    always_comb begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_i};
        rot      = {alu_a, alu_a} << alu_b[2:0];
        alu_sc_o = 1'b0;
        case (alu_cmd)
            3'b011:  alu_rslt = alu_a ^ alu_b;
            3'b100:  alu_rslt = rot[15:8];
            3'b101:  alu_rslt = alu_a & alu_b;
            3'b110:  alu_rslt = alu_a | alu_b;
            3'b111:  begin alu_rslt = sum[7:0]; alu_sc_o = sum[8]; end
            default: alu_rslt = '0;
        endcase
        alu_absj = (alu_a != 8'h00);
    end

    alu_issue_ctrl #(.REGS(8), .W(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_absj(alu_absj),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .branch_taken(branch_taken), .branch_target(branch_target), .carry(carry),
        .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present an instruction and return #1 after its acceptance edge (ISSUE cycle)
    task automatic accept(input logic [8:0] ins);
        int n = 0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: instr_ready=%b required=1", instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        acc_prev = acc_now;
        acc_now = cyc;
    endtask

    task automatic exec(input logic [8:0] ins);
        accept(ins);
        step();
        step();
    endtask

    task automatic rd_dbg(input logic [2:0] a);
        dbg_addr = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({instr_ready, alu_cmd, alu_a, alu_b, alu_sc_i, wb_valid, wb_addr, wb_data,
             branch_taken, branch_target, carry, halted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b cmd=%h a=%h b=%h sci=%b wbv=%b wba=%h wbd=%h bt=%b tgt=%h c=%b h=%b required all 0",
                     instr_ready, alu_cmd, alu_a, alu_b, alu_sc_i, wb_valid, wb_addr, wb_data,
                     branch_taken, branch_target, carry, halted);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", instr_ready); end
    endtask

    task automatic test_ldi_add();
        accept(enc(3'b000, 3'd1, 3'd5));
        checks++;
        if ({instr_ready, wb_valid} !== 2'b00) begin errors++; $display("FAIL ldi_issue: rdy/wbv got %b required 00", {instr_ready, wb_valid}); end
        step();
        checks++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 3'd1, 8'h05}) begin
            errors++; $display("FAIL ldi_r1_wb: got v=%b a=%h d=%h required v=1 a=1 d=05", wb_valid, wb_addr, wb_data);
        end
        step();
        exec(enc(3'b000, 3'd2, 3'd3));
        checks++;
        if (acc_now - acc_prev !== 3) begin errors++; $display("FAIL gap_ldi: got %0d required 3", acc_now - acc_prev); end
        accept(enc(3'b111, 3'd1, 3'd2));
        checks++;
        if (acc_now - acc_prev !== 3) begin errors++; $display("FAIL gap_add: got %0d required 3", acc_now - acc_prev); end
        checks++;
        if ({alu_cmd, alu_a, alu_b, alu_sc_i} !== {3'b111, 8'h05, 8'h03, 1'b0}) begin
            errors++; $display("FAIL add_operands: got cmd=%h a=%h b=%h sci=%b required 7 05 03 0", alu_cmd, alu_a, alu_b, alu_sc_i);
        end
        step();
        rd_dbg(3'd1);
        checks++;
        if ({wb_valid, wb_addr, wb_data, instr_ready} !== {1'b1, 3'd1, 8'h08, 1'b0}) begin
            errors++; $display("FAIL add_wb: got v=%b a=%h d=%h rdy=%b required 1 1 08 0", wb_valid, wb_addr, wb_data, instr_ready);
        end
        checks++;
        if (dbg_data !== 8'h05) begin errors++; $display("FAIL r1_before_commit: got %h required 05", dbg_data); end
        step();
        checks++;
        if ({dbg_data, carry, wb_valid, instr_ready} !== {8'h08, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL add_commit: got r1=%h c=%b wbv=%b rdy=%b required 08 0 0 1", dbg_data, carry, wb_valid, instr_ready);
        end
    endtask

    task automatic test_rot_carry();
        exec(enc(3'b000, 3'd1, 3'd7));
        exec(enc(3'b000, 3'd2, 3'd5));
        accept(enc(3'b100, 3'd1, 3'd2));
        checks++;
        if ({alu_cmd, alu_a, alu_b} !== {3'b100, 8'h07, 8'h05}) begin
            errors++; $display("FAIL rot_operands: got cmd=%h a=%h b=%h required 4 07 05", alu_cmd, alu_a, alu_b);
        end
        step();
        checks++;
        if (wb_data !== 8'hE0) begin errors++; $display("FAIL rot_result: got %h required E0", wb_data); end
        step();
        accept(enc(3'b111, 3'd1, 3'd1));
        checks++;
        if ({alu_a, alu_b, alu_sc_i} !== {8'hE0, 8'hE0, 1'b0}) begin
            errors++; $display("FAIL add_same_reg: got a=%h b=%h sci=%b required E0 E0 0", alu_a, alu_b, alu_sc_i);
        end
        step();
        checks++;
        if ({wb_data, carry} !== {8'hC0, 1'b0}) begin errors++; $display("FAIL add_c0_wb: got d=%h c=%b required C0 0", wb_data, carry); end
        step();
        checks++;
        if (carry !== 1'b1) begin errors++; $display("FAIL carry_set: got %b required 1", carry); end
        accept(enc(3'b111, 3'd3, 3'd3));
        checks++;
        if (alu_sc_i !== 1'b1) begin errors++; $display("FAIL sc_i_forward: got %b required 1", alu_sc_i); end
        step();
        checks++;
        if (wb_data !== 8'h01) begin errors++; $display("FAIL add_cin: got %h required 01", wb_data); end
        step();
        checks++;
        if (carry !== 1'b0) begin errors++; $display("FAIL carry_clear: got %b required 0", carry); end
    endtask

    task automatic test_rot_mask();
        exec(enc(3'b000, 3'd4, 3'd5));
        exec(enc(3'b111, 3'd4, 3'd4));
        exec(enc(3'b000, 3'd1, 3'd1));
        accept(enc(3'b100, 3'd1, 3'd4));
        checks++;
        if (alu_b !== 8'h02) begin errors++; $display("FAIL rot_mask: got %h required 02", alu_b); end
        step();
        step();
        rd_dbg(3'd4);
        checks++;
        if (dbg_data !== 8'h0A) begin errors++; $display("FAIL r4_value: got %h required 0A", dbg_data); end
        rd_dbg(3'd1);
        checks++;
        if (dbg_data !== 8'h04) begin errors++; $display("FAIL rot_masked_result: got %h required 04", dbg_data); end
    endtask

    task automatic test_branch();
        exec(enc(3'b000, 3'd5, 3'd6));
        exec(enc(3'b000, 3'd6, 3'd3));
        accept(enc(3'b010, 3'd5, 3'd6));
        checks++;
        if ({alu_cmd, alu_a} !== {3'b010, 8'h06}) begin errors++; $display("FAIL bnz_operands: got cmd=%h a=%h required 2 06", alu_cmd, alu_a); end
        step();
        checks++;
        if ({branch_taken, branch_target, wb_valid} !== {1'b1, 8'h03, 1'b0}) begin
            errors++; $display("FAIL bnz_taken: got bt=%b tgt=%h wbv=%b required 1 03 0", branch_taken, branch_target, wb_valid);
        end
        step();
        rd_dbg(3'd5);
        checks++;
        if ({branch_taken, dbg_data} !== {1'b0, 8'h06}) begin
            errors++; $display("FAIL bnz_after: got bt=%b r5=%h required 0 06", branch_taken, dbg_data);
        end
        accept(enc(3'b010, 3'd0, 3'd6));
        step();
        checks++;
        if ({branch_taken, wb_valid} !== 2'b00) begin errors++; $display("FAIL bnz_not_taken: got bt/wbv %b required 00", {branch_taken, wb_valid}); end
        step();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int readies = 0;
        @(negedge clk);
        instr = enc(3'b000, 3'd7, 3'd3);
        instr_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            pulses += int'(wb_valid);
            readies += int'(instr_ready);
        end
        instr_valid = 1'b0;
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL held_valid_wb_count: got %0d required 2", pulses); end
        checks++;
        if (readies !== 2) begin errors++; $display("FAIL held_valid_ready_count: got %0d required 2", readies); end
        step();
        step();
        rd_dbg(3'd7);
        checks++;
        if (dbg_data !== 8'h03) begin errors++; $display("FAIL r7_value: got %h required 03", dbg_data); end
    endtask

    task automatic test_halt();
        accept(enc(3'b001, 3'd0, 3'd0));
        checks++;
        if ({halted, instr_ready} !== 2'b10) begin errors++; $display("FAIL halt_set: got h/rdy %b required 10", {halted, instr_ready}); end
        instr = enc(3'b000, 3'd7, 3'd7);
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if ({halted, instr_ready, wb_valid} !== 3'b100) begin
                errors++; $display("FAIL halt_hold_%0d: got h/rdy/wbv %b required 100", k, {halted, instr_ready, wb_valid});
            end
        end
        instr_valid = 1'b0;
        rd_dbg(3'd7);
        checks++;
        if (dbg_data !== 8'h03) begin errors++; $display("FAIL halt_no_write: got r7=%h required 03", dbg_data); end
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++;
        if ({halted, instr_ready} !== 2'b01) begin errors++; $display("FAIL halt_cleared: got h/rdy %b required 01", {halted, instr_ready}); end
        for (int r = 0; r < 8; r++) begin
            rd_dbg(3'(r));
            checks++;
            if (dbg_data !== 8'h00) begin errors++; $display("FAIL rf_cleared_r%0d: got %h required 00", r, dbg_data); end
        end
    endtask

    task automatic test_reset_abort();
        exec(enc(3'b000, 3'd1, 3'd7));
        accept(enc(3'b111, 3'd1, 3'd1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL abort_no_wb: got %b required 0", wb_valid); end
        step();
        rd_dbg(3'd1);
        checks++;
        if ({instr_ready, wb_valid, carry, dbg_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL abort_state: got rdy=%b wbv=%b c=%b r1=%h required 1 0 0 00", instr_ready, wb_valid, carry, dbg_data);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_rot_carry();
        test_rot_mask();
        test_branch();
        test_back_to_back();
        test_halt();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that drives the 8-bit ALU from a 9-bit instruction stream. Each instruction is accepted over a valid/ready handshake, and the controller does four things:
- reads operands from an internal 8×8 register file;
- presents `alu_cmd`/operands to the combinational ALU;
- samples the ALU outputs;
- writes back the result, updates the carry flag or signals a branch.

It sits between instruction fetch and the ALU; it does not modify the ALU itself.

## Interface
Parameters:
- `REGS`, 8: register-file depth; fixed by the 3-bit register fields.
- `W`, 8: data width; must match the ALU.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction present.
- `instr` in 9: `[8:6]` opcode, `[5:3]` rd, `[2:0]` rs/imm.
- `instr_ready` out 1: controller can accept an instruction.
- `alu_cmd` out 3: command to the ALU.
- `alu_a` out 8: ALU `inA`.
- `alu_b` out 8: ALU `inB`.
- `alu_sc_i` out 1: ALU shift-carry input.
- `alu_rslt` in 8: ALU result.
- `alu_sc_o` in 1: ALU carry out.
- `alu_absj` in 1: ALU nonzero-test output.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_addr` out 3: destination register of that writeback.
- `wb_data` out 8: value written.
- `branch_taken` out 1: one-cycle pulse.
- `branch_target` out 8: target value, valid with `branch_taken`.
- `carry` out 1: architectural carry flag.
- `halted` out 1: sticky halt indication.
- `dbg_addr` in 3: debug register-file read address.
- `dbg_data` out 8: combinational read of `R[dbg_addr]`.

## Operation
Opcodes:
- 000 LDI: `R[rd] <= {5'b0, imm}`. ALU not used; `alu_cmd` is driven to 000.
- 001 HALT: sets `halted`. `instr_ready` stays 0 until `reset`. No writeback.
- 010 BNZ: `alu_a = R[rd]`.
  - If `alu_absj` = 1 when sampled: pulse `branch_taken` with `branch_target = R[rs]`.
  - No writeback; carry unchanged.
- 011 XOR, 101 AND, 110 OR: `alu_a = R[rd]`, `alu_b = R[rs]`. `R[rd] <= alu_rslt`; carry unchanged.
- 100 ROT: `alu_a = R[rd]`, `alu_b = R[rs] & 8'h07` (amount masked to 0..7). `R[rd] <= alu_rslt`.
- 111 ADD: `alu_a = R[rd]`, `alu_b = R[rs]`, `alu_sc_i = carry`. `R[rd] <= alu_rslt` and `carry <= alu_sc_o`.

General rules:
- `rd == rs` is legal. Both operands read the pre-instruction value.
- All registers, including R0, are writable; none is hardwired.
- The register file and `carry` update only in the WB state.

FSM states: IDLE, ISSUE, WB.
- IDLE:
  - `instr_ready = 1` unless `halted`.
  - When `instr_valid && instr_ready`, latch the instruction and the operands from the register file into the `alu_*` output registers, then go to ISSUE.
  - HALT goes directly to IDLE and sets `halted` on that edge.
- ISSUE:
  - `alu_*` outputs are stable.
  - `alu_rslt`, `alu_sc_o` and `alu_absj` are sampled at the end of the cycle.
  - Go to WB.
- WB:
  - Commit the register write and carry update.
  - Pulse `wb_valid` (LDI and ALU ops) or `branch_taken` (BNZ taken).
  - Go to IDLE.

Output behaviour:
- `alu_*` outputs hold their last values outside ISSUE.
- `wb_addr`/`wb_data` are meaningful only while `wb_valid` = 1.

## Timing
- Acceptance edge N, then ISSUE in cycle N+1, then WB in cycle N+2; `wb_valid` is high during cycle N+2.
- The next acceptance can occur at edge N+3. Throughput is 1 instruction per 3 cycles.
- The register-file write is visible on `dbg_data` from cycle N+3.
- `instr_ready` is 0 in ISSUE and WB. It depends only on state and `halted`, never on `instr_valid`.
- With `instr_valid` held high and `instr` stable, the instruction is accepted exactly once per handshake.

Reset:
- While `reset` = 1, all of these are 0 on the next edge: `instr_ready`, `alu_cmd`, `alu_a`, `alu_b`, `alu_sc_i`, `wb_valid`, `wb_addr`, `wb_data`, `branch_taken`, `branch_target`, `carry`, `halted`.
- The register file is cleared to 0 and the state is IDLE.
- The first cycle after `reset` falls has `instr_ready` = 1.
- Reset in ISSUE or WB aborts the instruction: no writeback, no branch pulse, no carry update.

Other boundaries:
- `instr_valid` while not ready is ignored and not queued.
- `instr_valid` after HALT is never accepted.

## Test plan
- After reset, send LDI R1,5; LDI R2,3; ADD R1,R2:
  - `wb_valid` fires in cycle N+2 of each instruction.
  - ADD shows `alu_a` = 0x05 and `alu_b` = 0x03, then writes `R1` = 0x08 with `carry` = 0.
  - Gap between acceptances is exactly 3 cycles.
- LDI R1,7; LDI R2,5; ROT R1,R2, then ADD R1,R1:
  - ROT writes `R1` = 0xE0.
  - ADD writes `R1` = 0xC0 and sets `carry` = 1.
  - A following ADD R3,R3 drives `alu_sc_i` = 1.
- LDI R4,5; ADD R4,R4 (`R4` = 0x0A); LDI R1,1; ROT R1,R4:
  - `alu_b` = 0x02 (masked).
  - `R1` = 0x04.
- Branch:
  - LDI R5,6; LDI R6,3; BNZ R5,R6: `branch_taken` pulses in WB with `branch_target` = 0x03, no `wb_valid`, `R5` unchanged.
  - BNZ R0,R6 with `R0` = 0: no pulse.
- HALT, then hold `instr_valid` = 1 for 10 cycles:
  - `halted` = 1 and `instr_ready` = 0 throughout; no further writes.
  - Reset clears `halted` and all registers read 0 via `dbg_addr`.
- Reset asserted in the ISSUE cycle of ADD R1,R1:
  - No `wb_valid`.
  - `R1` = 0, `carry` = 0.
  - `instr_ready` = 1 in the cycle after `reset` falls.
